// File: rtl/mem_read_checker_if.sv
// Bus bundle between mem_read_checker and the memory/controller side.
// MEM_READ_CHECKER_ERRLOG_EN adds the first-error log outputs.
interface mem_read_checker_if #(
   parameter int unsigned WORD_SIZE = 16,
   parameter int unsigned ADDR_W    = 8
);
   logic                 start;
   logic [WORD_SIZE-1:0] douta;
   logic                 rd_en;
   logic [ADDR_W-1:0]    addra;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [ADDR_W:0]      err_cnt;
`ifdef MEM_READ_CHECKER_ERRLOG_EN
   logic [ADDR_W-1:0]    first_err_addr;
   logic [WORD_SIZE-1:0] first_err_data;

   modport master (
      input  start, douta,
      output rd_en, addra, busy, done, pass, err_cnt, first_err_addr, first_err_data
   );
   modport slave (
      output start, douta,
      input  rd_en, addra, busy, done, pass, err_cnt, first_err_addr, first_err_data
   );
`else
   modport master (
      input  start, douta,
      output rd_en, addra, busy, done, pass, err_cnt
   );
   modport slave (
      output start, douta,
      input  rd_en, addra, busy, done, pass, err_cnt
   );
`endif
endinterface

// File: rtl/mem_read_checker.sv
// Sweeps all 2^ADDR_W addresses and checks read data against {~a, a}.
// Define MEM_READ_CHECKER_ERRLOG_EN to add first-mismatch address/data capture.
module mem_read_checker #(
   parameter int unsigned WORD_SIZE = 16,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned RD_LAT    = 1
) (
   input logic                clka,
   input logic                rst,
   mem_read_checker_if.master bus_io
);
   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [2:0]           drain_q, drain_d;
   logic [ADDR_W:0]      err_cnt_q, err_cnt_d;
   logic                 sweep_start;
   logic                 vld_pipe_q [RD_LAT];
   logic [ADDR_W-1:0]    addr_pipe_q [RD_LAT];
   logic [ADDR_W-1:0]    cmp_addr;
   logic [2*ADDR_W-1:0]  pattern;
   logic [WORD_SIZE-1:0] exp_word;
   logic                 mismatch;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      drain_d     = drain_q;
      sweep_start = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (bus_io.start) begin
               state_d     = StIssue;
               addr_d      = '0;
               sweep_start = 1'b1;
            end
         end
         StIssue: begin
            if (addr_q == {ADDR_W{1'b1}}) begin
               state_d = StDrain;
               drain_d = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         StDrain: begin
            if (drain_q == 3'(RD_LAT - 1)) state_d = StDone;
            else drain_d = drain_q + 3'd1;
         end
         default: state_d = StIdle;
      endcase
   end

   // Compare stage sees the address issued RD_LAT cycles earlier.
   assign cmp_addr = addr_pipe_q[RD_LAT-1];
   assign pattern  = {~cmp_addr, cmp_addr};
   assign exp_word = WORD_SIZE'(pattern);
   assign mismatch = vld_pipe_q[RD_LAT-1] && (bus_io.douta != exp_word);

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (sweep_start) err_cnt_d = '0;
      else if (mismatch) err_cnt_d = err_cnt_q + 1'b1;
   end

   always_ff @(posedge clka or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         drain_q   <= '0;
         err_cnt_q <= '0;
         for (int i = 0; i < int'(RD_LAT); i++) begin
            vld_pipe_q[i]  <= 1'b0;
            addr_pipe_q[i] <= '0;
         end
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         drain_q        <= drain_d;
         err_cnt_q      <= err_cnt_d;
         vld_pipe_q[0]  <= bus_io.rd_en;
         addr_pipe_q[0] <= addr_q;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            vld_pipe_q[i]  <= vld_pipe_q[i-1];
            addr_pipe_q[i] <= addr_pipe_q[i-1];
         end
      end
   end

   assign bus_io.rd_en   = (state_q == StIssue);
   assign bus_io.addra   = addr_q;
   assign bus_io.busy    = (state_q == StIssue) || (state_q == StDrain);
   assign bus_io.done    = (state_q == StDone);
   assign bus_io.pass    = (state_q == StDone) && (err_cnt_q == '0);
   assign bus_io.err_cnt = err_cnt_q;

`ifdef MEM_READ_CHECKER_ERRLOG_EN
   logic [ADDR_W-1:0]    first_err_addr_q, first_err_addr_d;
   logic [WORD_SIZE-1:0] first_err_data_q, first_err_data_d;

   // A zero count before this mismatch marks it as the first of the sweep.
   always_comb begin
      first_err_addr_d = first_err_addr_q;
      first_err_data_d = first_err_data_q;
      if (sweep_start) begin
         first_err_addr_d = '0;
         first_err_data_d = '0;
      end else if (mismatch && (err_cnt_q == '0)) begin
         first_err_addr_d = cmp_addr;
         first_err_data_d = bus_io.douta;
      end
   end

   always_ff @(posedge clka or negedge rst) begin
      if (!rst) begin
         first_err_addr_q <= '0;
         first_err_data_q <= '0;
      end else begin
         first_err_addr_q <= first_err_addr_d;
         first_err_data_q <= first_err_data_d;
      end
   end

   assign bus_io.first_err_addr = first_err_addr_q;
   assign bus_io.first_err_data = first_err_data_q;
`endif
endmodule

// File: tb/tb_mem_read_checker.sv
// Randomised self-checking bench for mem_read_checker (RD_LAT=1 and RD_LAT=3 instances).
// Expected results come from a corruption map over the address space, not from DUT internals.
module tb_mem_read_checker;
   localparam int unsigned AW    = 8;
   localparam int unsigned WS    = 16;
   localparam int          DEPTH = 256;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;
   bit   sel_b;

   logic [WS-1:0] cmask [DEPTH];

   mem_read_checker_if #(.WORD_SIZE(WS), .ADDR_W(AW)) ifa ();
   mem_read_checker_if #(.WORD_SIZE(WS), .ADDR_W(AW)) ifb ();

   mem_read_checker #(.WORD_SIZE(WS), .ADDR_W(AW), .RD_LAT(1)) u_dut_a (
      .clka   (clk),
      .rst    (rst),
      .bus_io (ifa)
   );
   mem_read_checker #(.WORD_SIZE(WS), .ADDR_W(AW), .RD_LAT(3)) u_dut_b (
      .clka   (clk),
      .rst    (rst),
      .bus_io (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WS-1:0] good_word(input logic [AW-1:0] a);
      logic [2*AW-1:0] p;
      p = {~a, a};
      return WS'(p);
   endfunction

   // Memory models: data appears 1 (A) or 3 (B) cycles after the address.
   logic [AW-1:0] b_d1, b_d2;
   always @(posedge clk) begin
      ifa.douta <= good_word(ifa.addra) ^ cmask[ifa.addra];
      b_d1      <= ifb.addra;
      b_d2      <= b_d1;
      ifb.douta <= good_word(b_d2) ^ cmask[b_d2];
   end

   logic          cur_rd_en, cur_busy, cur_done, cur_pass;
   logic [AW-1:0] cur_addra;
   logic [AW:0]   cur_err;
   assign cur_rd_en = sel_b ? ifb.rd_en   : ifa.rd_en;
   assign cur_busy  = sel_b ? ifb.busy    : ifa.busy;
   assign cur_done  = sel_b ? ifb.done    : ifa.done;
   assign cur_pass  = sel_b ? ifb.pass    : ifa.pass;
   assign cur_addra = sel_b ? ifb.addra   : ifa.addra;
   assign cur_err   = sel_b ? ifb.err_cnt : ifa.err_cnt;

   task automatic clear_mask();
      for (int i = 0; i < DEPTH; i++) cmask[i] = '0;
   endtask

   // Reference model: count and lowest address of corrupted words.
   task automatic model(output int cnt, output int first);
      cnt   = 0;
      first = -1;
      for (int i = 0; i < DEPTH; i++) begin
         if (cmask[i] != '0) begin
            if (first < 0) first = i;
            cnt++;
         end
      end
   endtask

   // Drives one start pulse (start launched after edge 0) and observes until done or timeout.
   task automatic do_sweep(input bit use_b, input bit poke_at_100, output int cyc, output int n_rd,
                           output bit seq_bad, output bit busy_bad, output logic [AW:0] err0);
      sel_b = use_b;
      @(posedge clk);
      #1;
      if (use_b) ifb.start = 1'b1;
      else ifa.start = 1'b1;
      cyc      = 0;
      n_rd     = 0;
      seq_bad  = 1'b0;
      busy_bad = 1'b0;
      err0     = '0;
      while (cyc < DEPTH + 40) begin
         @(posedge clk);
         cyc++;
         #1;
         ifa.start = 1'b0;
         ifb.start = 1'b0;
         @(negedge clk);
         if (cyc == 1) err0 = cur_err;
         if (cur_done === 1'b1) break;
         if (cur_busy !== 1'b1) busy_bad = 1'b1;
         if (cur_rd_en === 1'b1) begin
            if (cur_addra !== AW'(n_rd)) seq_bad = 1'b1;
            n_rd++;
            if (poke_at_100 && cur_addra == AW'(100)) begin
               if (use_b) ifb.start = 1'b1;
               else ifa.start = 1'b1;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2 rst = 1'b0;
      #20;
      n_vec++; if (ifa.rd_en !== 1'b0) begin n_err++; $display("FAIL rst_rd_en got %b want 0", ifa.rd_en); end
      n_vec++; if (ifa.addra !== '0) begin n_err++; $display("FAIL rst_addra got %0d want 0", ifa.addra); end
      n_vec++; if (ifa.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", ifa.busy); end
      n_vec++; if (ifa.done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", ifa.done); end
      n_vec++; if (ifa.pass !== 1'b0) begin n_err++; $display("FAIL rst_pass got %b want 0", ifa.pass); end
      n_vec++; if (ifa.err_cnt !== '0) begin n_err++; $display("FAIL rst_err got %0d want 0", ifa.err_cnt); end
      n_vec++; if (ifb.busy !== 1'b0 || ifb.done !== 1'b0) begin
         n_err++; $display("FAIL rst_b_idle got busy=%b done=%b want 0 0", ifb.busy, ifb.done);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      n_vec++; if (ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
         n_err++; $display("FAIL post_rst_idle got busy=%b done=%b want 0 0", ifa.busy, ifa.done);
      end
   endtask

   task automatic test_clean_sweep(input bit use_b);
      int cyc, n_rd, exp_cyc;
      bit seq_bad, busy_bad;
      logic [AW:0] err0;
      exp_cyc = use_b ? DEPTH + 3 + 1 : DEPTH + 1 + 1;
      clear_mask();
      do_sweep(use_b, 1'b0, cyc, n_rd, seq_bad, busy_bad, err0);
      n_vec++; if (cyc !== exp_cyc) begin n_err++; $display("FAIL clean_latency lat_b=%0b got %0d want %0d", use_b, cyc, exp_cyc); end
      n_vec++; if (n_rd !== DEPTH) begin n_err++; $display("FAIL clean_rd_cycles got %0d want %0d", n_rd, DEPTH); end
      n_vec++; if (seq_bad !== 1'b0) begin n_err++; $display("FAIL clean_addr_seq got %b want 0", seq_bad); end
      n_vec++; if (busy_bad !== 1'b0 || cur_busy !== 1'b0) begin
         n_err++; $display("FAIL clean_busy got bad=%b at_done=%b want 0 0", busy_bad, cur_busy);
      end
      n_vec++; if (cur_err !== '0) begin n_err++; $display("FAIL clean_err got %0d want 0", cur_err); end
      n_vec++; if (cur_pass !== 1'b1) begin n_err++; $display("FAIL clean_pass got %b want 1", cur_pass); end
      repeat (3) @(negedge clk);
      n_vec++; if (cur_done !== 1'b1 || cur_addra !== AW'(DEPTH - 1) || cur_rd_en !== 1'b0) begin
         n_err++; $display("FAIL done_hold got done=%b addra=%0d rd_en=%b want 1 %0d 0",
                           cur_done, cur_addra, cur_rd_en, DEPTH - 1);
      end
   endtask

   task automatic check_errs(input bit use_b, input string tag);
      int cyc, n_rd, cnt, first;
      bit seq_bad, busy_bad;
      logic [AW:0] err0;
      model(cnt, first);
      do_sweep(use_b, 1'b0, cyc, n_rd, seq_bad, busy_bad, err0);
      n_vec++; if (cur_err !== (AW + 1)'(cnt)) begin n_err++; $display("FAIL %s_err_cnt got %0d want %0d", tag, cur_err, cnt); end
      n_vec++; if (cur_pass !== (cnt == 0)) begin n_err++; $display("FAIL %s_pass got %b want %b", tag, cur_pass, cnt == 0); end
      n_vec++; if (err0 !== '0) begin n_err++; $display("FAIL %s_err_clear got %0d want 0", tag, err0); end
`ifdef MEM_READ_CHECKER_ERRLOG_EN
      begin
         logic [AW-1:0] ea;
         logic [WS-1:0] ed;
         ea = (cnt == 0) ? '0 : AW'(first);
         ed = (cnt == 0) ? '0 : good_word(AW'(first)) ^ cmask[first];
         n_vec++; if ((sel_b ? ifb.first_err_addr : ifa.first_err_addr) !== ea) begin
            n_err++; $display("FAIL %s_first_addr got %0d want %0d", tag,
                              sel_b ? ifb.first_err_addr : ifa.first_err_addr, ea);
         end
         n_vec++; if ((sel_b ? ifb.first_err_data : ifa.first_err_data) !== ed) begin
            n_err++; $display("FAIL %s_first_data got %h want %h", tag,
                              sel_b ? ifb.first_err_data : ifa.first_err_data, ed);
         end
      end
`endif
   endtask

   task automatic test_corrupt_5_200();
      clear_mask();
      cmask[5]   = 16'h0001;
      cmask[200] = 16'h8000;
      check_errs(1'b0, "corrupt_5_200");
   endtask

   task automatic test_random(input bit use_b, input int rounds);
      for (int r = 0; r < rounds; r++) begin
         int n;
         clear_mask();
         n = $urandom_range(0, 6);
         for (int k = 0; k < n; k++) cmask[$urandom_range(0, DEPTH - 1)] = WS'($urandom_range(1, 16'hffff));
         check_errs(use_b, use_b ? "rand_lat3" : "rand_lat1");
      end
   endtask

   task automatic test_start_ignored();
      int cyc, n_rd;
      bit seq_bad, busy_bad;
      logic [AW:0] err0;
      clear_mask();
      cmask[50] = 16'h0f00;
      do_sweep(1'b0, 1'b1, cyc, n_rd, seq_bad, busy_bad, err0);
      n_vec++; if (cyc !== DEPTH + 2 || n_rd !== DEPTH || seq_bad !== 1'b0) begin
         n_err++; $display("FAIL start_in_issue got cyc=%0d rd=%0d seq_bad=%b want %0d %0d 0",
                           cyc, n_rd, seq_bad, DEPTH + 2, DEPTH);
      end
      n_vec++; if (cur_err !== 9'd1) begin n_err++; $display("FAIL start_in_issue_err got %0d want 1", cur_err); end
   endtask

   task automatic test_reset_mid_sweep();
      int guard;
      clear_mask();
      cmask[127] = 16'h00ff;
      cmask[128] = 16'hff00;
      sel_b = 1'b0;
      @(posedge clk);
      #1 ifa.start = 1'b1;
      @(posedge clk);
      #1 ifa.start = 1'b0;
      guard = 0;
      @(negedge clk);
      while (!(ifa.rd_en === 1'b1 && ifa.addra == AW'(128)) && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      n_vec++; if (guard >= 400) begin n_err++; $display("FAIL mid_rst_reach got timeout want addra=128"); end
      rst = 1'b0;
      #1;
      n_vec++; if ({ifa.rd_en, ifa.busy, ifa.done, ifa.pass} !== 4'b0 || ifa.addra !== '0 || ifa.err_cnt !== '0) begin
         n_err++; $display("FAIL mid_rst_outputs got rd=%b busy=%b done=%b pass=%b addr=%0d err=%0d want all 0",
                           ifa.rd_en, ifa.busy, ifa.done, ifa.pass, ifa.addra, ifa.err_cnt);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      n_vec++; if (ifa.busy !== 1'b0 || ifa.done !== 1'b0 || ifa.err_cnt !== '0) begin
         n_err++; $display("FAIL mid_rst_idle got busy=%b done=%b err=%0d want 0 0 0", ifa.busy, ifa.done, ifa.err_cnt);
      end
      test_clean_sweep(1'b0);
   endtask

   task automatic test_restart_after_fail();
      clear_mask();
      cmask[0]   = 16'h1234;
      cmask[255] = 16'h0001;
      cmask[77]  = 16'h4000;
      check_errs(1'b0, "fail_sweep");
      clear_mask();
      check_errs(1'b0, "restart_clean");
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      sel_b     = 1'b0;
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      clear_mask();
      test_reset();
      test_clean_sweep(1'b0);
      test_corrupt_5_200();
      test_random(1'b0, 4);
      test_clean_sweep(1'b1);
      test_random(1'b1, 2);
      test_start_ignored();
      test_reset_mid_sweep();
      test_restart_after_fail();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
